// File: rtl/sweep_pkg.sv
// Shared types for the frequency sweep generator: FSM state enum, sweep mode
// enum and mode encodings, plus a helper that folds triangle modes onto their
// non-triangle equivalents when FREQ_SWEEP_TRIANGLE_EN is not defined.
package sweep_pkg;

  // Mode encodings as presented on the mode input
  localparam logic [1:0] MODE_ENC_SINGLE_UP   = 2'd0;
  localparam logic [1:0] MODE_ENC_SAWTOOTH    = 2'd1;
  localparam logic [1:0] MODE_ENC_TRI_REPEAT  = 2'd2;
  localparam logic [1:0] MODE_ENC_TRI_SINGLE  = 2'd3;

  typedef enum logic [1:0] {
    MODE_SINGLE_UP  = MODE_ENC_SINGLE_UP,
    MODE_SAWTOOTH   = MODE_ENC_SAWTOOTH,
    MODE_TRI_REPEAT = MODE_ENC_TRI_REPEAT,
    MODE_TRI_SINGLE = MODE_ENC_TRI_SINGLE
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
`ifdef FREQ_SWEEP_TRIANGLE_EN
    ST_DOWN = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_e;

  // Without triangle support, repeat-triangle acts as sawtooth and
  // single-triangle acts as a single up sweep.
  function automatic mode_e effective_mode(input logic [1:0] m);
`ifdef FREQ_SWEEP_TRIANGLE_EN
    return mode_e'(m);
`else
    case (m)
      MODE_ENC_TRI_REPEAT: return MODE_SAWTOOTH;
      MODE_ENC_TRI_SINGLE: return MODE_SINGLE_UP;
      default:             return mode_e'(m);
    endcase
`endif
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..dwell while enabled, flags the terminal count and
// wraps back to zero on the cycle after it. clear forces the count to zero.
module dwell_timer #(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [CW-1:0] dwell,
  output logic          tc
);

  logic [CW-1:0] count_reg;

  assign tc = (count_reg == dwell);

  // Count up while enabled; restart at zero after the terminal count
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tc ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/freq_sweep.sv
// Frequency sweep generator driving a DDS frequency control word.
// Sweeps f_start..f_stop in f_step increments, holding each word for dwell+1
// cycles, in single-up, sawtooth or (with FREQ_SWEEP_TRIANGLE_EN defined)
// triangle repeat / triangle single modes. Sweep parameters are captured
// when a start is accepted in IDLE; stop aborts back to IDLE at any time.
module freq_sweep
  import sweep_pkg::*;
#(
  parameter int PW = 32,
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] f_start,
  input  logic [PW-1:0] f_stop,
  input  logic [PW-1:0] f_step,
  input  logic [CW-1:0] dwell,
  output logic [PW-1:0] freq,
  output logic          dds_en,
  output logic          busy,
  output logic          done
);

  state_e        state_reg, state_next;
  mode_e         mode_reg;
  logic [PW-1:0] f_start_reg, f_stop_reg, f_step_reg;
  logic [CW-1:0] dwell_reg;
  logic [PW-1:0] freq_reg, freq_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          accept;
  logic          timer_clear, timer_en, tc;
  logic          degenerate;
  logic [PW:0]   up_sum;
  logic [PW-1:0] up_next;

  // A start is only taken from IDLE, and stop always wins over it
  assign accept = (state_reg == ST_IDLE) && start && !stop;

  // Empty or zero-step ranges just hold f_start for one dwell period
  assign degenerate = (f_start_reg >= f_stop_reg) || (f_step_reg == '0);

  // Upward step computed one bit wider so a sum past the top cannot wrap
  assign up_sum  = {1'b0, freq_reg} + {1'b0, f_step_reg};
  assign up_next = (up_sum >= {1'b0, f_stop_reg}) ? f_stop_reg : up_sum[PW-1:0];

`ifdef FREQ_SWEEP_TRIANGLE_EN
  logic [PW:0]   down_diff;
  logic [PW-1:0] down_next;

  // Downward step; the borrow bit catches underflow before the clamp test
  assign down_diff = {1'b0, freq_reg} - {1'b0, f_step_reg};
  assign down_next = (down_diff[PW] || (down_diff[PW-1:0] <= f_start_reg)) ?
                     f_start_reg : down_diff[PW-1:0];
`endif

  dwell_timer #(
    .CW(CW)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .en    (timer_en),
    .dwell (dwell_reg),
    .tc    (tc)
  );

  // Capture the sweep parameters on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg    <= MODE_SINGLE_UP;
      f_start_reg <= '0;
      f_stop_reg  <= '0;
      f_step_reg  <= '0;
      dwell_reg   <= '0;
    end else if (accept) begin
      mode_reg    <= effective_mode(mode);
      f_start_reg <= f_start;
      f_stop_reg  <= f_stop;
      f_step_reg  <= f_step;
      dwell_reg   <= dwell;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      freq_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      freq_reg  <= freq_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Next-state, next frequency word and dwell timer control
  always_comb begin
    state_next  = state_reg;
    freq_next   = freq_reg;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next  = ST_UP;
          freq_next   = f_start;
          timer_clear = 1'b1;
        end
      end

      ST_UP: begin
        if (stop) begin
          state_next  = ST_IDLE;
          timer_clear = 1'b1;
        end else begin
          timer_en = 1'b1;
          if (tc) begin
            if (degenerate) begin
              state_next = ST_DONE;
            end else if (freq_reg != f_stop_reg) begin
              freq_next = up_next;
            end else begin
              // f_stop has been held a full dwell: the up segment is over
              case (mode_reg)
                MODE_SAWTOOTH: freq_next = f_start_reg;
`ifdef FREQ_SWEEP_TRIANGLE_EN
                MODE_TRI_REPEAT, MODE_TRI_SINGLE: begin
                  state_next = ST_DOWN;
                  freq_next  = down_next;
                end
`endif
                default: state_next = ST_DONE;
              endcase
            end
          end
        end
      end

`ifdef FREQ_SWEEP_TRIANGLE_EN
      ST_DOWN: begin
        if (stop) begin
          state_next  = ST_IDLE;
          timer_clear = 1'b1;
        end else begin
          timer_en = 1'b1;
          if (tc) begin
            if (freq_reg != f_start_reg) begin
              freq_next = down_next;
            end else if (mode_reg == MODE_TRI_REPEAT) begin
              state_next = ST_UP;
              freq_next  = up_next;
            end else begin
              state_next = ST_DONE;
            end
          end
        end
      end
`endif

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

`ifdef FREQ_SWEEP_TRIANGLE_EN
    busy_next = (state_next == ST_UP) || (state_next == ST_DOWN);
`else
    busy_next = (state_next == ST_UP);
`endif
    done_next = (state_next == ST_DONE);
  end

  assign freq   = freq_reg;
  assign busy   = busy_reg;
  assign dds_en = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_freq_sweep.sv
// Self-checking bench for freq_sweep. The expected frequency sequence of each
// sweep is built from the sweep rules as a list of segment values, each
// repeated dwell+1 times, and compared cycle by cycle with the DUT.
// Honours FREQ_SWEEP_TRIANGLE_EN the same way the design does.
module tb_freq_sweep;
  localparam int PW = 32;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [PW-1:0] f_start, f_stop, f_step;
  logic [CW-1:0] dwell;
  logic [PW-1:0] freq;
  logic          dds_en, busy, done;

  int errors = 0;
  int checks = 0;
  longint exp_q[$];

  freq_sweep #(.PW(PW), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .f_start (f_start),
    .f_stop  (f_stop),
    .f_step  (f_step),
    .dwell   (dwell),
    .freq    (freq),
    .dds_en  (dds_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_mode(input int m);
`ifdef FREQ_SWEEP_TRIANGLE_EN
    return m;
`else
    if (m == 2) return 1;
    if (m == 3) return 0;
    return m;
`endif
  endfunction

  // Expected per-cycle frequency words for one sweep (bounded to max_cyc for
  // repeating modes); single=1 when the sweep ends with a done pulse.
  task automatic build_seq(input int m, input longint fs, input longint fe,
                           input longint st, input int dw, input int max_cyc,
                           output bit single);
    longint u[$];
    longint dn[$];
    longint vals[$];
    longint v;
    exp_q.delete();
    single = 1'b1;
    if (fs >= fe || st == 0) begin
      vals.push_back(fs);
    end else begin
      v = fs;
      u.push_back(v);
      while (v < fe) begin
        v = (v + st >= fe) ? fe : v + st;
        u.push_back(v);
      end
      v = fe;
      while (v > fs) begin
        v = (v - st <= fs) ? fs : v - st;
        dn.push_back(v);
      end
      case (m)
        0: foreach (u[k]) vals.push_back(u[k]);
        1: begin
          single = 1'b0;
          while (vals.size() * (dw + 1) < max_cyc)
            foreach (u[k]) vals.push_back(u[k]);
        end
        2: begin
          single = 1'b0;
          foreach (u[k]) vals.push_back(u[k]);
          while (vals.size() * (dw + 1) < max_cyc) begin
            foreach (dn[k]) vals.push_back(dn[k]);
            for (int k = 1; k < u.size(); k++) vals.push_back(u[k]);
          end
        end
        default: begin
          foreach (u[k]) vals.push_back(u[k]);
          foreach (dn[k]) vals.push_back(dn[k]);
        end
      endcase
    end
    foreach (vals[i])
      for (int r = 0; r <= dw; r++) exp_q.push_back(vals[i]);
    if (!single)
      while (exp_q.size() > max_cyc) void'(exp_q.pop_back());
  endtask

  // Run one complete sweep from IDLE and check every cycle; repeating modes
  // are stopped after max_cyc cycles. With noise set, start and all sweep
  // inputs are scrambled while busy and must have no effect.
  task automatic run_sweep(input string name, input int m, input longint fs,
                           input longint fe, input longint st, input int dw,
                           input int max_cyc, input bit noise);
    bit single;
    longint e;
    logic [PW-1:0] ef;
    logic [PW-1:0] last;
    build_seq(eff_mode(m), fs, fe, st, dw, max_cyc, single);
    mode    = m[1:0];
    f_start = fs[PW-1:0];
    f_stop  = fe[PW-1:0];
    f_step  = st[PW-1:0];
    dwell   = dw[CW-1:0];
    stop    = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    last  = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e  = exp_q[i];
      ef = e[PW-1:0];
      checks++;
      if (freq !== ef || busy !== 1'b1 || dds_en !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: got freq=%0d busy=%b dds_en=%b done=%b, expected freq=%0d busy=1 dds_en=1 done=0",
                 name, i, freq, busy, dds_en, done, ef);
      end
      last = ef;
      if (noise) begin
        f_start = $urandom;
        f_stop  = $urandom;
        f_step  = $urandom;
        dwell   = CW'($urandom);
        mode    = 2'($urandom);
        start   = ($urandom_range(0, 3) == 0);
      end
      if (!single && i == exp_q.size() - 1) stop = 1'b1;
      tick();
    end
    start = 1'b0;
    if (single) begin
      checks++;
      if (freq !== last || busy !== 1'b0 || dds_en !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL %s done_cycle: got freq=%0d busy=%b dds_en=%b done=%b, expected freq=%0d busy=0 dds_en=0 done=1",
                 name, freq, busy, dds_en, done, last);
      end
      tick();
      checks++;
      if (freq !== last || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: got freq=%0d busy=%b done=%b, expected freq=%0d busy=0 done=0",
                 name, freq, busy, done, last);
      end
    end else begin
      stop = 1'b0;
      checks++;
      if (freq !== last || busy !== 1'b0 || dds_en !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s stop: got freq=%0d busy=%b dds_en=%b done=%b, expected freq=%0d busy=0 dds_en=0 done=0",
                 name, freq, busy, dds_en, done, last);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; stop = 1'b0; mode = 2'd0;
    f_start = 32'd5; f_stop = 32'd50; f_step = 32'd5; dwell = '0;
    tick(); tick();
    checks++;
    if (freq !== '0 || busy !== 1'b0 || dds_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got freq=%0d busy=%b dds_en=%b done=%b, expected all 0",
               freq, busy, dds_en, done);
    end
    rst = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    run_sweep("single_up",       0, 100, 130, 10, 2, 0, 1'b0);
    run_sweep("single_clamp",    0, 100, 125, 10, 2, 0, 1'b0);
    run_sweep("triangle_repeat", 2, 100, 120, 10, 0, 30, 1'b0);
    run_sweep("sawtooth",        1, 100, 120, 10, 0, 30, 1'b0);
    run_sweep("zero_step",       0, 100, 200, 0, 4, 0, 1'b0);
    run_sweep("empty_range_tri", 2, 300, 150, 5, 1, 0, 1'b0);
    run_sweep("equal_range_saw", 1, 77, 77, 3, 2, 0, 1'b0);
    run_sweep("triangle_single", 3, 10, 47, 9, 1, 0, 1'b0);
  endtask

  task automatic test_boundary;
    run_sweep("top_clamp_up",   3, 64'hFFFF_FFC0, 64'hFFFF_FFFF, 64'h30, 1, 0, 1'b0);
    run_sweep("huge_step_tri",  2, 64'h10, 64'hF000_0000, 64'hF000_0000, 0, 25, 1'b0);
    run_sweep("bottom_clamp",   3, 0, 64'h25, 64'h10, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    int m, dw, range;
    longint fs, fe, st;
    for (int n = 0; n < 25; n++) begin
      m  = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      fs = longint'($urandom_range(0, 1000));
      range = $urandom_range(1, 2000);
      if ($urandom_range(0, 5) == 0) fe = fs - longint'($urandom_range(0, 1000)) % (fs + 1);
      else fe = fs + range;
      if ($urandom_range(0, 7) == 0) st = 0;
      else st = longint'($urandom_range(range / 16 + 1, range + 50));
      run_sweep($sformatf("random%0d_m%0d", n, m), m, fs, fe, st, dw, 60, 1'b1);
    end
  endtask

  task automatic test_abort;
    bit single;
    logic [PW-1:0] held;
    longint e;
    build_seq(0, 200, 400, 20, 1, 0, single);
    e = exp_q[6];
    held = e[PW-1:0];
    mode = 2'd0; f_start = 32'd200; f_stop = 32'd400; f_step = 32'd20; dwell = 24'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    checks++;
    if (freq !== held || busy !== 1'b0 || dds_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort: got freq=%0d busy=%b dds_en=%b done=%b, expected freq=%0d busy=0 dds_en=0 done=0",
               freq, busy, dds_en, done, held);
    end
    tick();
    checks++;
    if (freq !== held || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got freq=%0d busy=%b done=%b, expected freq=%0d busy=0 done=0",
               freq, busy, done, held);
    end
  endtask

  task automatic test_start_with_stop;
    logic [PW-1:0] held;
    held = freq;
    mode = 2'd1; f_start = 32'd9; f_stop = 32'd99; f_step = 32'd9; dwell = '0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || dds_en !== 1'b0 || freq !== held) begin
      errors++;
      $display("FAIL start_with_stop: got busy=%b dds_en=%b freq=%0d, expected busy=0 dds_en=0 freq=%0d",
               busy, dds_en, freq, held);
    end
  endtask

  task automatic test_reset_mid_sweep;
    mode = 2'd1; f_start = 32'd500; f_stop = 32'd900; f_step = 32'd50; dwell = 24'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1; start = 1'b1; stop = 1'b0;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if (freq !== '0 || busy !== 1'b0 || dds_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_sweep: got freq=%0d busy=%b dds_en=%b done=%b, expected all 0",
               freq, busy, dds_en, done);
    end
    tick();
    checks++;
    if (freq !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got freq=%0d busy=%b done=%b, expected all 0",
               freq, busy, done);
    end
    run_sweep("after_reset", 0, 40, 70, 15, 1, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    test_reset();
    test_directed();
    test_boundary();
    test_abort();
    test_start_with_stop();
    test_reset_mid_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
